// File: rtl/btn_step_pulser.sv
// Push-button front end: two-flop synchroniser, press/release debounce FSM and
// optional auto-repeat, producing single-cycle step pulses on en.
module btn_step_pulser #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned REPEAT_EN       = 1,
  parameter int unsigned REPEAT_DELAY    = 25000000,
  parameter int unsigned REPEAT_PERIOD   = 5000000,
  parameter int unsigned CNT_W           = 26
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_in,
  output logic en,
  output logic btn_stable
);

  typedef enum logic [1:0] {IDLE, PRESS_CHK, HELD, REL_CHK} state_t;
  typedef enum logic {FIRST, PERIODIC} phase_t;

  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] DLY_LAST = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] PER_LAST = CNT_W'(REPEAT_PERIOD - 1);

  state_t           state, state_nx;
  phase_t           rep_phase, phase_nx;
  logic [CNT_W-1:0] deb_cnt, deb_nx;
  logic [CNT_W-1:0] rep_cnt, rep_nx;
  logic             s1, s2;
  logic             sync;
  logic             en_nx;

  assign sync = s2;

  always_comb begin
    state_nx = state;
    deb_nx   = deb_cnt;
    rep_nx   = rep_cnt;
    phase_nx = rep_phase;
    en_nx    = 1'b0;
    case (state)
      IDLE: begin
        if (sync) begin
          state_nx = PRESS_CHK;
          deb_nx   = '0;
        end
      end
      PRESS_CHK: begin
        if (!sync) begin
          state_nx = IDLE;
        end else if (deb_cnt == DEB_LAST) begin
          state_nx = HELD;
          en_nx    = 1'b1;
          rep_nx   = '0;
          phase_nx = FIRST;
        end else begin
          deb_nx = deb_cnt + CNT_W'(1);
        end
      end
      HELD: begin
        if (!sync) begin
          state_nx = REL_CHK;
          deb_nx   = '0;
        end else if (REPEAT_EN != 0) begin
          // The first repeat waits REPEAT_DELAY, later ones REPEAT_PERIOD.
          if (rep_phase == FIRST && rep_cnt == DLY_LAST) begin
            en_nx    = 1'b1;
            rep_nx   = '0;
            phase_nx = PERIODIC;
          end else if (rep_phase == PERIODIC && rep_cnt == PER_LAST) begin
            en_nx  = 1'b1;
            rep_nx = '0;
          end else begin
            rep_nx = rep_cnt + CNT_W'(1);
          end
        end
      end
      REL_CHK: begin
        if (sync) begin
          state_nx = HELD;
          rep_nx   = '0;
          phase_nx = FIRST;
        end else if (deb_cnt == DEB_LAST) begin
          state_nx = IDLE;
        end else begin
          deb_nx = deb_cnt + CNT_W'(1);
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      s1         <= 1'b0;
      s2         <= 1'b0;
      deb_cnt    <= '0;
      rep_cnt    <= '0;
      rep_phase  <= FIRST;
      en         <= 1'b0;
      btn_stable <= 1'b0;
    end else begin
      s1         <= btn_in;
      s2         <= s1;
      state      <= state_nx;
      deb_cnt    <= deb_nx;
      rep_cnt    <= rep_nx;
      rep_phase  <= phase_nx;
      en         <= en_nx;
      btn_stable <= (state_nx == HELD) || (state_nx == REL_CHK);
    end
  end

endmodule
